// File: rtl/demux_seq_pkg.sv
// Shared constants, FSM state type and one-hot helper for the demux select sequencer.
package demux_seq_pkg;

    localparam int NUM_CH  = 8;
    localparam int CH_W    = 3;
    localparam int DWELL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] code;
        code     = '0;
        code[ch] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/onehot_enc_3_8.sv
// Combinational 3-to-8 one-hot encoder with enable; output is all-zero when disabled.
module onehot_enc_3_8
    import demux_seq_pkg::*;
(
    input  logic [CH_W-1:0]   idx,
    input  logic              en,
    output logic [NUM_CH-1:0] code
);

    always_comb begin
        code = '0;
        if (en) begin
            code = onehot(idx);
        end
    end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Sequences one-hot select codes for a 1:8 demux with a forced all-zero gap between channels.
// Optional channel sweep mode is enabled by defining SEQ_SCAN_EN (adds the i_scan input).
module demux_sel_sequencer
    import demux_seq_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [CH_W-1:0]    i_ch,
    input  logic               i_data,
    input  logic [DWELL_W-1:0] i_dwell,
`ifdef SEQ_SCAN_EN
    input  logic               i_scan,
`endif
    output logic               o_a,
    output logic [NUM_CH-1:0]  o_sel_code,
    output logic               o_busy,
    output logic               o_done
);

    seq_state_t         state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [CH_W-1:0]    ch_q, ch_n;
    logic               data_q, data_n;
    logic               scan_q, scan_n;
    logic [CH_W-1:0]    left_q, left_n;
    logic               done_n;
    logic               scan_in;
    logic [NUM_CH-1:0]  sel_n;

`ifdef SEQ_SCAN_EN
    assign scan_in = i_scan;
`else
    assign scan_in = 1'b0;
`endif

    // left_q counts channels still to visit after the current one in a sweep
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dwell_n = dwell_q;
        ch_n    = ch_q;
        data_n  = data_q;
        scan_n  = scan_q;
        left_n  = left_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    state_n = DRIVE;
                    cnt_n   = i_dwell;
                    dwell_n = i_dwell;
                    ch_n    = i_ch;
                    data_n  = i_data;
                    scan_n  = scan_in;
                    left_n  = scan_in ? CH_W'(NUM_CH - 1) : '0;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    done_n  = !(scan_q && (left_q != '0));
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (scan_q && (left_q != '0)) begin
                    state_n = DRIVE;
                    ch_n    = ch_q + 1'b1;
                    left_n  = left_q - 1'b1;
                    cnt_n   = dwell_q;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    onehot_enc_3_8 u_enc (
        .idx  (ch_n),
        .en   (state_n == DRIVE),
        .code (sel_n)
    );

    // Outputs are registered from the next-state view so they line up with the state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dwell_q    <= '0;
            ch_q       <= '0;
            data_q     <= 1'b0;
            scan_q     <= 1'b0;
            left_q     <= '0;
            o_sel_code <= '0;
            o_a        <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_ready    <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dwell_q    <= dwell_n;
            ch_q       <= ch_n;
            data_q     <= data_n;
            scan_q     <= scan_n;
            left_q     <= left_n;
            o_sel_code <= sel_n;
            o_a        <= (state_n == DRIVE) && data_n;
            o_busy     <= (state_n != IDLE);
            o_done     <= done_n;
            o_ready    <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Scoreboard bench for demux_sel_sequencer: per-cycle expected outputs are queued as requests are driven.
module tb_demux_sel_sequencer;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [2:0] i_ch;
    logic       i_data;
    logic [3:0] i_dwell;
    logic       o_a;
    logic [7:0] o_sel_code;
    logic       o_busy;
    logic       o_done;
`ifdef SEQ_SCAN_EN
    logic       i_scan;
`endif

    typedef struct packed {
        logic [7:0] sel;
        logic       a;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    demux_sel_sequencer dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_ch       (i_ch),
        .i_data     (i_data),
        .i_dwell    (i_dwell),
`ifdef SEQ_SCAN_EN
        .i_scan     (i_scan),
`endif
        .o_a        (o_a),
        .o_sel_code (o_sel_code),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // The select bus must never carry more than one active line
    always @(negedge i_clk) begin
        if (!i_rst) begin
            checks++;
            if (!$onehot0(o_sel_code)) begin
                failures++;
                $display("[TB] FAIL sel_onehot0: got sel=%h, want at most one bit set", o_sel_code);
            end
        end
    end

    function automatic exp_t observed();
        exp_t o;
        o.sel   = o_sel_code;
        o.a     = o_a;
        o.busy  = o_busy;
        o.done  = o_done;
        o.ready = o_ready;
        return o;
    endfunction

    task automatic push_drive(input int ch, input bit data, input int dwell);
        exp_t e;
        e.sel   = 8'd1 << ch;
        e.a     = data;
        e.busy  = 1'b1;
        e.done  = 1'b0;
        e.ready = 1'b0;
        for (int i = 0; i <= dwell; i++) exp_q.push_back(e);
    endtask

    task automatic push_gap(input bit done);
        exp_t e;
        e.sel   = 8'h00;
        e.a     = 1'b0;
        e.busy  = 1'b1;
        e.done  = done;
        e.ready = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        exp_t e;
        e.sel   = 8'h00;
        e.a     = 1'b0;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.ready = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input int ch, input bit data, input int dwell);
        i_valid = 1'b1;
        i_ch    = 3'(ch);
        i_data  = data;
        i_dwell = 4'(dwell);
    endtask

    task automatic test_reset();
        exp_t e, o;
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_ch    = 3'd5;
        i_data  = 1'b1;
        i_dwell = 4'd3;
`ifdef SEQ_SCAN_EN
        i_scan  = 1'b0;
`endif
        push_idle();
        push_idle();
        for (int c = 0; c < 2; c++) begin
            @(posedge i_clk);
            #1;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset cycle %0d: got %h, want %h", c, o, e);
            end
        end
        i_rst   = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic test_single();
        exp_t e, o;
        int n;
        push_drive(3, 1'b1, 2);
        push_gap(1'b1);
        push_idle();
        drive_req(3, 1'b1, 2);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL single cycle %0d: got %h, want %h", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        int n;
        push_drive(0, 1'b1, 0);
        push_gap(1'b1);
        push_idle();
        push_drive(7, 1'b1, 0);
        push_gap(1'b1);
        push_idle();
        drive_req(0, 1'b1, 0);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            if (c == 0) i_ch = 3'd7;
            if (c == 3) i_valid = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h, want %h", c, o, e);
            end
        end
    endtask

    task automatic test_long_dwell();
        exp_t e, o;
        int n;
        push_drive(6, 1'b0, 15);
        push_gap(1'b1);
        push_idle();
        drive_req(6, 1'b0, 15);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL long_dwell cycle %0d: got %h, want %h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e, o;
        int n;
        push_drive(2, 1'b1, 1);
        push_idle();
        push_idle();
        push_idle();
        drive_req(2, 1'b1, 5);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            if (c == 1) i_rst = 1'b1;
            if (c == 2) i_rst = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset_abort cycle %0d: got %h, want %h", c, o, e);
            end
        end
    endtask

    task automatic test_input_change();
        exp_t e, o;
        int n;
        push_drive(1, 1'b1, 3);
        push_gap(1'b1);
        push_idle();
        drive_req(1, 1'b1, 3);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            if (c == 0) begin
                i_ch    = 3'd4;
                i_data  = 1'b0;
                i_dwell = 4'd9;
            end
            if (c == 1) i_valid = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL input_change cycle %0d: got %h, want %h", c, o, e);
            end
        end
    endtask

    task automatic test_random();
        exp_t e, o;
        int n, ch, dw;
        bit dat;
        for (int r = 0; r < 6; r++) begin
            ch  = int'($urandom_range(0, 7));
            dw  = int'($urandom_range(0, 4));
            dat = 1'($urandom_range(0, 1));
            push_drive(ch, dat, dw);
            push_gap(1'b1);
            push_idle();
            drive_req(ch, dat, dw);
            n = exp_q.size();
            for (int c = 0; c < n; c++) begin
                @(posedge i_clk);
                #1;
                i_valid = 1'b0;
                e = exp_q.pop_front();
                o = observed();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("[TB] FAIL random req %0d cycle %0d: got %h, want %h", r, c, o, e);
                end
            end
        end
    endtask

`ifdef SEQ_SCAN_EN
    task automatic test_scan();
        exp_t e, o;
        int n;
        for (int k = 0; k < 8; k++) begin
            push_drive((5 + k) % 8, 1'b1, 0);
            push_gap(k == 7);
        end
        push_idle();
        drive_req(5, 1'b1, 0);
        i_scan = 1'b1;
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            i_scan  = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL scan cycle %0d: got %h, want %h", c, o, e);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_long_dwell();
        test_reset_abort();
        test_input_change();
        test_random();
`ifdef SEQ_SCAN_EN
        test_scan();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
